// File: rtl/fact_pkg.sv
// Shared types and helpers for the sequential factorial engine.
// Holds the FSM state encoding and the product-width rule.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // acc < 2^out_w and i < 2^in_w, so the product always fits
  function automatic int prod_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/factorial_seq.sv
// Sequential factorial engine: one multiply per clock, saturating result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/num operand
// handshake; out_valid/out_ready/fact/overflow result handshake; busy.
module factorial_seq
  import fact_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] fact,
  output logic             overflow,
  output logic             busy
);

  localparam int PROD_W = prod_w(IN_W, OUT_W);

  generate
    if (OUT_W < 2 || IN_W < 1) begin : g_bad_params
      $error("factorial_seq: need OUT_W >= 2 and IN_W >= 1");
    end
  endgenerate

  state_t state, state_d;

  logic [OUT_W-1:0]  acc, acc_d;
  logic [IN_W:0]     i_q, i_d;
  logic [IN_W-1:0]   n_q, n_d;
  logic              ovf, ovf_d;

  logic [PROD_W-1:0] prod;
  logic [IN_W-1:0]   prod_hi;
  logic [OUT_W-1:0]  prod_lo;
  logic              last;

  // i stays <= n during CALC, so zero-extending both sides is exact
  assign prod    = {{IN_W{1'b0}}, acc}
                 * {{(OUT_W-1){1'b0}}, i_q};
  assign prod_hi = prod[PROD_W-1:OUT_W];
  assign prod_lo = prod[OUT_W-1:0];
  assign last    = (i_q == {1'b0, n_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      i_q   <= '0;
      n_q   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      i_q   <= i_d;
      n_q   <= n_d;
      ovf   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    i_d     = i_q;
    n_d     = n_q;
    ovf_d   = ovf;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          n_d   = num;
          acc_d = OUT_W'(1);
          i_d   = (IN_W+1)'(2);
          ovf_d = 1'b0;
          // 0! and 1! need no multiply
          if (num <= IN_W'(1)) state_d = DONE;
          else                 state_d = CALC;
        end
      end
      CALC: begin
        if (prod_hi != '0) begin
          // saturate and stop early; later terms only grow
          acc_d   = '1;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (last) begin
          acc_d   = prod_lo;
          state_d = DONE;
        end else begin
          acc_d = prod_lo;
          i_d   = i_q + (IN_W+1)'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign fact      = acc;
  assign overflow  = ovf;

endmodule

// File: tb/tb_factorial_seq.sv
// Self-checking bench for factorial_seq: two instances (OUT_W 16 and 48)
// checked each cycle against a behavioural factorial model.
module tb_factorial_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] iv   = 2'b00;
  logic [1:0] ordy = 2'b00;
  logic [3:0] nm [2];
  logic [1:0] rdy, ovd, bsy, ovf;
  logic [15:0] fact_a;
  logic [47:0] fact_b;
  logic [63:0] fw [2];

  assign fw[0] = 64'(fact_a);
  assign fw[1] = 64'(fact_b);

  factorial_seq #(.IN_W(4), .OUT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(rdy[0]), .num(nm[0]),
    .out_valid(ovd[0]), .out_ready(ordy[0]),
    .fact(fact_a), .overflow(ovf[0]), .busy(bsy[0])
  );

  factorial_seq #(.IN_W(4), .OUT_W(48)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(rdy[1]), .num(nm[1]),
    .out_valid(ovd[1]), .out_ready(ordy[1]),
    .fact(fact_b), .overflow(ovf[1]), .busy(bsy[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, a, e);
    end
  endtask

  // plain-arithmetic factorial with saturation and latency
  function automatic longint unsigned ref_val(input int n, input int ow);
    longint unsigned a = 1;
    for (int k = 2; k <= n; k++) begin
      if (((a * k) >> ow) != 0) return (64'd1 << ow) - 1;
      a = a * k;
    end
    return a;
  endfunction

  function automatic bit ref_ov(input int n, input int ow);
    longint unsigned a = 1;
    for (int k = 2; k <= n; k++) begin
      if (((a * k) >> ow) != 0) return 1'b1;
      a = a * k;
    end
    return 1'b0;
  endfunction

  function automatic int ref_lat(input int n, input int ow);
    longint unsigned a = 1;
    for (int k = 2; k <= n; k++) begin
      if (((a * k) >> ow) != 0) return k - 1;
      a = a * k;
    end
    return (n <= 1) ? 0 : n - 1;
  endfunction

  function automatic int ow_of(input int d);
    return (d == 0) ? 16 : 48;
  endfunction

  // model: 0 idle, 1 computing, 2 result held
  int          ph [2];
  int          wt [2];
  logic [63:0] ef [2];
  logic        eo [2];
  logic        rf [2];
  logic        m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ph[d] <= 0;
        rf[d] <= 1'b1;
      end else begin
        case (ph[d])
          0: if (iv[d]) begin
            ef[d] <= ref_val(int'(nm[d]), ow_of(d));
            eo[d] <= ref_ov(int'(nm[d]), ow_of(d));
            rf[d] <= 1'b0;
            wt[d] <= ref_lat(int'(nm[d]), ow_of(d));
            ph[d] <= (ref_lat(int'(nm[d]), ow_of(d)) == 0) ? 2 : 1;
          end
          1: begin
            if (wt[d] == 1) ph[d] <= 2;
            else            wt[d] <= wt[d] - 1;
          end
          default: if (ordy[d]) ph[d] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), 64'(rdy[d]), 64'(ph[d] == 0));
        chk($sformatf("out_valid[%0d]", d), 64'(ovd[d]), 64'(ph[d] == 2));
        chk($sformatf("busy[%0d]", d), 64'(bsy[d]), 64'(ph[d] != 0));
        if (ph[d] == 2) begin
          chk($sformatf("fact[%0d]", d), fw[d], ef[d]);
          chk($sformatf("overflow[%0d]", d), 64'(ovf[d]), 64'(eo[d]));
        end else if (rf[d]) begin
          chk($sformatf("rst_fact[%0d]", d), fw[d], 64'd0);
          chk($sformatf("rst_ovf[%0d]", d), 64'(ovf[d]), 64'd0);
        end
      end
    end
  end

  task automatic run_op(input int d, input int n, input int hold,
                        input bit noise, output int lat,
                        output logic [63:0] f, output logic ov);
    int g = 0;
    @(posedge clk); #1;
    iv[d] = 1'b1;
    nm[d] = 4'(n);
    @(negedge clk);
    while (!rdy[d] && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 64'(g < 100), 64'd1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!ovd[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("result_wait", 64'(lat < 100), 64'd1);
    f  = fw[d];
    ov = ovf[d];
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        iv[d] = 1'($urandom_range(1));
        nm[d] = 4'($urandom_range(15));
      end
      @(negedge clk);
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic op_lit(input int d, input int n, input logic [63:0] ef_l,
                        input logic eo_l, input int lat_l);
    int lat;
    logic [63:0] f;
    logic ov;
    run_op(d, n, 0, 1'b0, lat, f, ov);
    chk($sformatf("lit_fact n=%0d", n), f, ef_l);
    chk($sformatf("lit_ovf n=%0d", n), 64'(ov), 64'(eo_l));
    chk($sformatf("lit_lat n=%0d", n), 64'(lat), 64'(lat_l));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] f;
    logic ov;
    nm[0] = 4'd5;
    nm[1] = 4'd5;
    iv    = 2'b11;

    // model pins
    chk("ref 5!", ref_val(5, 32), 64'd120);
    chk("ref 8! lat", 64'(ref_lat(8, 16)), 64'd7);
    chk("ref 9! sat", ref_val(9, 16), 64'hFFFF);
    chk("ref 15! lat16", 64'(ref_lat(15, 16)), 64'd8);
    chk("ref 15! w48", ref_val(15, 48), 64'd1307674368000);
    chk("ref 0! lat", 64'(ref_lat(0, 16)), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    iv  = 2'b00;
    @(negedge clk);
    chk("rst in_ready", 64'(rdy[0]), 64'd1);
    chk("rst out_valid", 64'(ovd[0]), 64'd0);
    chk("rst busy", 64'(bsy[0]), 64'd0);
    chk("rst fact", 64'(fact_a), 64'd0);
    chk("rst overflow", 64'(ovf[0]), 64'd0);

    op_lit(0, 0, 64'd1, 1'b0, 0);
    op_lit(0, 1, 64'd1, 1'b0, 0);
    op_lit(0, 5, 64'd120, 1'b0, 4);
    op_lit(0, 8, 64'd40320, 1'b0, 7);
    op_lit(0, 9, 64'hFFFF, 1'b1, 8);
    op_lit(0, 15, 64'hFFFF, 1'b1, 8);
    op_lit(1, 15, 64'd1307674368000, 1'b0, 14);
    op_lit(1, 5, 64'd120, 1'b0, 4);

    // backpressure with in_valid noise while the result is held
    run_op(0, 6, 10, 1'b1, lat, f, ov);
    chk("bp fact", f, 64'd720);
    chk("bp ovf", 64'(ov), 64'd0);
    @(negedge clk);
    chk("bp idle", 64'(rdy[0]), 64'd1);

    // reset during the third CALC cycle
    @(posedge clk); #1;
    iv[0] = 1'b1;
    nm[0] = 4'd7;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 64'(rdy[0]), 64'd1);
    chk("abort out_valid", 64'(ovd[0]), 64'd0);
    chk("abort busy", 64'(bsy[0]), 64'd0);
    chk("abort fact", 64'(fact_a), 64'd0);
    chk("abort ovf", 64'(ovf[0]), 64'd0);
    op_lit(0, 4, 64'd24, 1'b0, 3);

    for (int t = 0; t < 60; t++) begin
      int d = (t % 4 == 3) ? 1 : 0;
      int n = int'($urandom_range(15));
      run_op(d, n, int'($urandom_range(3)), 1'($urandom_range(1)),
             lat, f, ov);
      chk("rnd lat", 64'(lat), 64'(ref_lat(n, ow_of(d))));
      repeat ($urandom_range(2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
